inst_fetch_unit: RTL

//  Fetch/decode front end of the multi-cycle RV32I core; directly upstream of the control unit.
//  - Owns the PC and the instruction register (IR).
//  - Fetches from instruction memory over a req/ack handshake.
//  - Supplies opcode/funct3/funct7, register indices and the sign-extended immediate.
//  - Applies the PC increment/jump commands issued by the control unit.

---
 rtl/inst_fetch_unit_if.sv | 9 +
 rtl/inst_fetch_unit.sv | 83 ++++++++
 2 files changed

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: instruction memory request/acknowledge bus
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC/IR owner, req/ack instruction fetch, field and immediate decode, PC commands
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  inst_fetch_unit_if.master        imem,
  input  logic                     i_fetch_req,
  input  logic                     i_pc_go_next,
  input  logic                     i_pc_jump,
  input  logic                     i_pc_jump_sel,
  input  logic [31:0]              i_jump_target,
  output logic                     o_inst_valid,
  output logic [6:0]               o_opcode,
  output logic [2:0]               o_funct3,
  output logic [6:0]               o_funct7,
  output logic [4:0]               o_rs1,
  output logic [4:0]               o_rs2,
  output logic [4:0]               o_rd,
  output logic [31:0]              o_imm,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_pc_cur,
  output logic                     o_jump_misalign,
  output logic                     o_busy
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_pc_cur, r_ir, w_imm, w_target, w_pc_next;
  logic        r_misalign, w_hold, w_misalign;
  logic [6:0]  w_op;
  always_comb begin
    w_next = r_state == IDLE ? (i_fetch_req ? REQ : IDLE) :
             r_state == REQ  ? (imem.imem_ack ? HOLD : REQ) :
                               (i_fetch_req ? REQ : HOLD);
    w_op  = r_ir[6:0];
    w_imm = (w_op == 7'b0010011 || w_op == 7'b0000011 || w_op == 7'b1100111) ? {{20{r_ir[31]}}, r_ir[31:20]} :
            w_op == 7'b0100011 ? {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]} :
            w_op == 7'b1100011 ? {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0} :
            w_op == 7'b0110111 ? {r_ir[31:12], 12'b0} :
            w_op == 7'b1101111 ? {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0} :
                                 32'b0;
    w_hold     = r_state == HOLD;
    w_target   = i_pc_jump_sel ? (i_jump_target & 32'hFFFF_FFFE) : r_pc_cur + w_imm;
    w_misalign = w_hold & i_pc_jump & w_target[1];
    // a jump beats an increment; a misaligned jump leaves pc where it was
    w_pc_next  = !w_hold      ? r_pc :
                 i_pc_jump    ? (w_target[1] ? r_pc : w_target) :
                 i_pc_go_next ? r_pc + 32'(PC_STEP) :
                                r_pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_pc_cur   <= RESET_PC;
      r_ir       <= 32'h0000_0013;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_pc       <= w_pc_next;
      r_misalign <= w_misalign;
      if (r_state == REQ && imem.imem_ack) begin
        r_ir     <= imem.imem_rdata;
        r_pc_cur <= r_pc;
      end
    end
  end
  assign imem.imem_req   = r_state == REQ;
  assign imem.imem_addr  = r_pc;
  assign o_busy          = r_state == REQ;
  assign o_inst_valid    = r_state == HOLD;
  assign o_opcode        = r_ir[6:0];
  assign o_funct3        = r_ir[14:12];
  assign o_funct7        = r_ir[31:25];
  assign o_rs1           = r_ir[19:15];
  assign o_rs2           = r_ir[24:20];
  assign o_rd            = r_ir[11:7];
  assign o_imm           = w_imm;
  assign o_pc            = r_pc;
  assign o_pc_cur        = r_pc_cur;
  assign o_jump_misalign = r_misalign;
endmodule
